// File: rtl/bcd_digit_assembler_pkg.sv
// Shared FSM state encodings, error cause codes and sizing helpers
// for the two-digit BCD frame assembler.
package bcd_digit_assembler_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_HAVE_TENS = 2'd1;
  localparam logic [1:0] ST_DISCARD   = 2'd2;
  localparam logic [1:0] ST_EMIT      = 2'd3;

  localparam logic [1:0] ERR_DIGIT   = 2'd0;
  localparam logic [1:0] ERR_RANGE   = 2'd1;
  localparam logic [1:0] ERR_NO_LAST = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Wide enough to hold the limit itself once the count reaches it.
  function automatic int ctr_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  function automatic logic is_bcd(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_assembler_timeout.sv
// Idle-cycle counter for the tens-to-units gap; expired is combinational so a
// handshake arriving in the expiry cycle can still take priority upstream.
module bcd_timeout_ctr
  import bcd_digit_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = ctr_width(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;

  // Expiry fires during the idle cycle that would bring the count to the limit.
  assign expired = enable && (cnt_q == LIMIT);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_digit_assembler.sv
// Assembles a 1- or 2-digit BCD frame into {tens bit, units nibble}, rejecting bad frames.
// Latency 1 cycle from last handshake to dat_valid_o; ready drops only in the emit cycle.
module bcd_digit_assembler
  import bcd_digit_assembler_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dig_valid_i,
  output logic       dig_ready_o,
  input  logic [3:0] dig_dat_i,
  input  logic       dig_last_i,
  output logic [4:0] dat_bcd_o,
  output logic       dat_valid_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  logic [1:0] state_q, state_d;
  logic       tens_q, tens_d;
  logic [3:0] units_q, units_d;
  logic [4:0] dat_q;
  logic       dat_valid_q, err_q;
  logic [1:0] err_code_q, err_code_d;
  logic       emit_d, err_d;
  logic       hs, expired;

  assign dig_ready_o = !rst_i && (state_q != ST_EMIT);
  assign hs          = dig_valid_i && dig_ready_o;

  bcd_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state_q != ST_HAVE_TENS),
    .enable  ((state_q == ST_HAVE_TENS) && !hs),
    .expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    units_d    = units_q;
    emit_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (dig_last_i) begin
            if (is_bcd(dig_dat_i)) begin
              tens_d  = 1'b0;
              units_d = dig_dat_i;
              emit_d  = 1'b1;
              state_d = ST_EMIT;
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_DIGIT;
            end
          end else if (dig_dat_i <= 4'd1) begin
            tens_d  = dig_dat_i[0];
            state_d = ST_HAVE_TENS;
          end else begin
            // A tens digit of 2..9 already puts the value above 15.
            err_d      = 1'b1;
            err_code_d = is_bcd(dig_dat_i) ? ERR_RANGE : ERR_DIGIT;
            state_d    = ST_DISCARD;
          end
        end
      end
      ST_HAVE_TENS: begin
        if (hs) begin
          if (!dig_last_i) begin
            err_d      = 1'b1;
            err_code_d = ERR_NO_LAST;
            tens_d     = 1'b0;
            state_d    = ST_DISCARD;
          end else if (!is_bcd(dig_dat_i)) begin
            err_d      = 1'b1;
            err_code_d = ERR_DIGIT;
            tens_d     = 1'b0;
            state_d    = ST_IDLE;
          end else if (tens_q && (dig_dat_i > 4'd5)) begin
            err_d      = 1'b1;
            err_code_d = ERR_RANGE;
            tens_d     = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            units_d = dig_dat_i;
            emit_d  = 1'b1;
            state_d = ST_EMIT;
          end
        end else if (expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          tens_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (hs && dig_last_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      tens_q      <= 1'b0;
      units_q     <= 4'd0;
      dat_q       <= 5'd0;
      dat_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      tens_q      <= tens_d;
      units_q     <= units_d;
      dat_valid_q <= emit_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      if (emit_d) begin
        dat_q <= {tens_d, units_d};
      end
    end
  end

  assign dat_bcd_o   = dat_q;
  assign dat_valid_o = dat_valid_q;
  assign err_o       = err_q;
  assign err_code_o  = err_code_q;

endmodule

// File: doc/bcd_digit_assembler.md
BCD_DIGIT_ASSEMBLER -- requirements
Module: bcd_digit_assembler

Interface
REQ-001 Parameter SHALL be: TIMEOUT_CYCLES, 255, max idle cycles allowed between tens and units digit (legal range 1..255).
REQ-002 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 dig_valid_i  input  1  digit offered this cycle.
REQ-005 dig_ready_o  output  1  block accepts digit this cycle; handshake = dig_valid_i & dig_ready_o.
REQ-006 dig_dat_i  input  4  BCD digit.
REQ-007 dig_last_i  input  1  marks final (units) digit of a frame.
REQ-008 dat_bcd_o  output  5  assembled value {tens bit, units nibble}; feeds the BCD-to-binary stage directly.
REQ-009 dat_valid_o  output  1  one-cycle pulse: dat_bcd_o updated.
REQ-010 err_o  output  1  one-cycle pulse: frame rejected.
REQ-011 err_code_o  output  2  cause, valid when err_o=1: 0 digit>9, 1 value>15, 2 missing last, 3 timeout.

Function
REQ-012 Frame SHALL be 1 digit (last=1, units only, tens=0) or 2 digits (tens, then units with last=1).
REQ-013 FSM states SHALL be IDLE, HAVE_TENS, DISCARD, EMIT.
REQ-014 dig_ready_o SHALL be 1 in IDLE, HAVE_TENS, DISCARD; 0 in EMIT and whenever rst_i=1.
REQ-015 IDLE, handshake, last=1, digit<=9: latch units, tens=0 -> EMIT.
REQ-016 IDLE, handshake, last=0, digit<=1: latch tens -> HAVE_TENS, clear timeout counter.
REQ-017 IDLE, handshake, last=0, digit in 2..9: err code 1 -> DISCARD; digit>9: err code 0 -> DISCARD.
REQ-018 HAVE_TENS, handshake, last=1: digit>9 -> err code 0, IDLE; tens=1 and digit>5 -> err code 1, IDLE; else latch units -> EMIT.
REQ-019 HAVE_TENS, handshake, last=0: err code 2 -> DISCARD.
REQ-020 DISCARD SHALL consume digits without checking until a handshake with last=1, then -> IDLE with no output and no further error.
REQ-021 Timeout counter SHALL increment each HAVE_TENS cycle without handshake; on reaching TIMEOUT_CYCLES: err code 3, -> IDLE, tens discarded.
REQ-022 Handshake in the same cycle as timeout expiry SHALL win; no timeout error.
REQ-023 EMIT (exactly 1 cycle): dat_bcd_o updated, dat_valid_o=1 -> IDLE; latency = 1 cycle from last handshake to dat_valid_o.
REQ-024 dat_bcd_o SHALL hold its last emitted value between frames and across errors; dat_bcd_o[3:0] always <=9 and value <=15.
REQ-025 err_o and dat_valid_o SHALL never assert in the same cycle; err_o asserts in the cycle after the offending handshake/expiry.

Reset
REQ-026 While rst_i=1 (at clock edge): state IDLE, dat_bcd_o=0, dat_valid_o=0, err_o=0, err_code_o=0, timeout counter=0, latched digits=0.
REQ-027 Reset mid-frame SHALL abandon partial frame with no output and no error pulse; first cycle after release is IDLE with dig_ready_o=1.

Structure
REQ-028 Shared package SHALL hold the FSM state enum and the four err_code constants.
REQ-029 Timeout counter SHALL be one sub-module bcd_timeout_ctr (clear, enable, expired), width derived from TIMEOUT_CYCLES.

Verification
REQ-030 Digits 1(last=0), 3(last=1) back-to-back -> next cycle dat_bcd_o=5'b10011, dat_valid_o=1 pulse, err_o=0.
REQ-031 Single digit 7(last=1) -> dat_bcd_o=5'b00111, one valid pulse; dig_ready_o=0 for exactly that EMIT cycle.
REQ-032 Digits 1,8(last=1) -> err_o=1, code 1, dat_bcd_o unchanged; digit 12(last=1) from IDLE -> code 0.
REQ-033 Digits 0,4(last=0),9,2(last=1) -> err code 2 once, digits 9 and 2 dropped, next frame 6(last=1) -> dat_bcd_o=5'b00110.
REQ-034 TIMEOUT_CYCLES=4: digit 1(last=0), idle 4 cycles -> err code 3; units digit offered on the 4th idle cycle instead -> accepted, no error.
REQ-035 rst_i pulsed while in HAVE_TENS -> no valid/err pulse, outputs zero, next frame 2(last=1) -> dat_bcd_o=5'b00010.
